pin_capture: RTL and testbench



---
 rtl/pin_capture_pkg.sv | 9 +
 rtl/pin_sync.sv | 31 +++
 rtl/pin_capture.sv | 65 ++++++
 tb/tb_pin_capture.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pin_capture_pkg.sv
// rtl/pin_capture_pkg.sv - shared constants and types for the pin capture stage
package pin_capture_pkg;

  localparam int PTIME_W         = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [PTIME_W-1:0] ptime_t;

endpackage : pin_capture_pkg

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - N-flop synchroniser with synchronous active-high reset
//   clk  in  1  sampling clock
//   rst  in  1  synchronous active-high reset, clears every stage
//   d    in  1  asynchronous input
//   q    out 1  synchronised output (last stage)
module pin_sync
  import pin_capture_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF  // must be 2 or more
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Plain shift chain: nothing may sit between stages, so only the first
  // flop can see a metastable input.
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : pin_sync

// File: rtl/pin_capture.sv
// rtl/pin_capture.sv - synchronise a serial pin, strobe rising edges and timestamp them
//   clk600   in  1        capture clock
//   rst      in  1        synchronous active-high reset
//   pin_in   in  1        asynchronous serial pin
//   pin_out  out 1        synchronised, registered copy of pin_in
//   str      out 1        one-cycle strobe per detected rising edge
//   ptime    out PTIME_W  frame counter value at the last detected rising edge
module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int PTIME_W     = pin_capture_pkg::PTIME_W
) (
  input  logic               clk600,
  input  logic               rst,
  input  logic               pin_in,
  output logic               pin_out,
  output logic               str,
  output logic [PTIME_W-1:0] ptime
);

  logic               s;
  logic               s_d;
  logic               rise;
  logic [PTIME_W-1:0] fcnt;

  pin_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk600),
    .rst(rst),
    .d  (pin_in),
    .q  (s)
  );

  assign rise = s & ~s_d;

  // Free-running frame counter; wraps silently.
  always_ff @(posedge clk600) begin
    if (rst) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // All outputs update together; the timestamp is the counter value seen in
  // the detection cycle, and it is simply overwritten by the next rise.
  always_ff @(posedge clk600) begin
    if (rst) begin
      s_d     <= 1'b0;
      pin_out <= 1'b0;
      str     <= 1'b0;
      ptime   <= '0;
    end else begin
      s_d     <= s;
      pin_out <= s;
      str     <= rise;
      if (rise) begin
        ptime <= fcnt;
      end
    end
  end

endmodule : pin_capture

// File: tb/tb_pin_capture.sv
// tb/tb_pin_capture.sv - scoreboard bench for pin_capture
`timescale 1ns / 10ps
module tb_pin_capture;

  logic       clk600 = 1'b0;
  logic       rst;
  logic       pin_in;
  logic       pin_out;
  logic       str;
  logic [2:0] ptime;

  pin_capture dut (
    .clk600 (clk600),
    .rst    (rst),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .str    (str),
    .ptime  (ptime)
  );

  always #5 clk600 = ~clk600;

  typedef struct {
    int due;
    int pt;
  } exp_t;

  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  int ecnt = 0;
  int str_cnt = 0;
  int last_edge = -1;
  int last_pt = -1;
  int prev_pt = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a rise sampled at edge N (edges counted from reset release)
  // must appear as a strobe after edge N+2 carrying (N+1) mod 8; pin_out
  // follows the pin as sampled two edges earlier.
  logic h1 = 1'b0, h2 = 1'b0, samp, rst_s;
  logic exp_pin = 1'b0, exp_str;
  int   exp_ptime = 0;

  always @(posedge clk600) begin
    samp  = pin_in;
    rst_s = rst;
    if (rst_s === 1'b1) begin
      ecnt = 0;
      h1 = 1'b0;
      h2 = 1'b0;
      exp_pin = 1'b0;
      exp_ptime = 0;
      sb.delete();
    end else begin
      ecnt++;
      exp_pin = h2;
      if (samp && !h1) sb.push_back('{ecnt + 2, (ecnt + 1) % 8});
      h2 = h1;
      h1 = samp;
    end
    #1;
    exp_str = (!rst_s && sb.size() > 0 && sb[0].due == ecnt);
    check("str", str, exp_str);
    if (str === 1'b1) begin
      str_cnt++;
      prev_pt = last_pt;
      last_pt = ptime;
      last_edge = ecnt;
    end
    if (exp_str) exp_ptime = sb.pop_front().pt;
    check("ptime", ptime, exp_ptime);
    check("pin_out", pin_out, exp_pin);
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk600);
  endtask

  int base;

  initial begin
    rst = 1'b1;
    pin_in = 1'b0;
    // reset with a toggling pin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk600);
      pin_in = ~pin_in;
    end
    @(negedge clk600);
    rst = 1'b0;
    pin_in = 1'b0;

    // single rise before edge 5, held three cycles
    base = str_cnt;
    negs(4);
    pin_in = 1'b1;
    negs(3);
    pin_in = 1'b0;
    negs(6);
    check("single_cnt", str_cnt - base, 1);
    check("single_edge", last_edge, 7);
    check("single_ptime", last_pt, 6);

    // wrap: rise detected at fcnt 7, next rise two cycles later
    while ((ecnt + 1) % 8 != 6) negs(1);
    pin_in = 1'b1;
    negs(1);
    pin_in = 1'b0;
    negs(1);
    pin_in = 1'b1;
    negs(1);
    pin_in = 1'b0;
    negs(6);
    check("wrap_first", prev_pt, 7);
    check("wrap_second", last_pt, 1);

    // reset in the middle of a pulse
    pin_in = 1'b1;
    negs(6);
    rst = 1'b1;
    negs(1);
    rst = 1'b0;
    base = str_cnt;
    negs(5);
    check("rstpulse_cnt", str_cnt - base, 1);
    check("rstpulse_edge", last_edge, 3);
    check("rstpulse_ptime", last_pt, 2);
    pin_in = 1'b0;
    negs(4);

    // pulse train: 30 pulses, 2.5 cycles wide, period 10.25 cycles
    base = str_cnt;
    #0.5;
    for (int k = 0; k < 30; k++) begin
      pin_in = 1'b1;
      #25;
      pin_in = 1'b0;
      #77.5;
    end
    negs(6);
    check("train_cnt", str_cnt - base, 30);

    // sub-cycle glitch between edges
    base = str_cnt;
    #2;
    pin_in = 1'b1;
    #0.4;
    pin_in = 1'b0;
    negs(6);
    check("glitch_le1", (str_cnt - base) <= 1, 1);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pin_capture
